dual_ram_be: RTL and testbench

DUAL_RAM_BE -- requirements
Module: dual_ram_be

---
 rtl/dual_ram_be.sv | 152 +++++++++++++++
 tb/tb_dual_ram_be.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_be.sv
// Simple dual-port RAM with byte-lane write strobes and 1-cycle registered read.
// Define DUAL_RAM_INIT_EN to zero the whole array after every reset before ready rises.
module dual_ram_be #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_NUM = 4096,
  parameter int BW      = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic [BW-1:0] w_strb,
  input  logic          ren,
  input  logic [AW-1:0] r_addr,
  output logic [DW-1:0] r_data,
  output logic          r_valid,
  output logic          ready
);

  // Word index width; AW is assumed to be at least this wide.
  localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [AW:0] MEM_LIM = (AW + 1)'(MEM_NUM);

  logic          ready_reg;
  logic          ready_next;
  logic          r_valid_reg;
  logic          w_in_range;
  logic          r_in_range;
  logic          wr_fire;
  logic          rd_fire;
  logic          collision;
  logic          clr_we;
  logic [IW-1:0] clr_addr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] mem_waddr;

  assign w_in_range = ({1'b0, w_addr} < MEM_LIM);
  assign r_in_range = ({1'b0, r_addr} < MEM_LIM);
  assign wr_fire    = ready_reg && wen && w_in_range;
  assign rd_fire    = ready_reg && ren;
  assign collision  = wr_fire && rd_fire && r_in_range && (r_addr == w_addr);

  assign w_idx     = w_addr[IW-1:0];
  assign r_idx     = r_addr[IW-1:0];
  assign mem_waddr = clr_we ? clr_addr : w_idx;

`ifdef DUAL_RAM_INIT_EN
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [IW-1:0] cnt_reg;
  logic [IW-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ready is registered from the state, so it rises one edge after the last clear write.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    ready_next = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == IW'(MEM_NUM - 1)) begin
          state_next = READY;
          cnt_next   = '0;
        end
      end
      READY: begin
        ready_next = 1'b1;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_reg;
`else
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
  assign ready_next = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg   <= 1'b0;
      r_valid_reg <= 1'b0;
    end else begin
      ready_reg   <= ready_next;
      r_valid_reg <= rd_fire;
    end
  end

  assign ready   = ready_reg;
  assign r_valid = r_valid_reg;

  // One 8-bit RAM per byte lane; a same-address write forwards its enabled lanes to the read.
  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_lane
      logic [7:0] mem [MEM_NUM];
      logic [7:0] rd_q;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = clr_we || (wr_fire && w_strb[gi]);
      assign lane_wdata = clr_we ? 8'h00 : w_data[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[mem_waddr] <= lane_wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= 8'h00;
        end else if (rd_fire) begin
          if (!r_in_range) begin
            rd_q <= 8'h00;
          end else if (collision && w_strb[gi]) begin
            rd_q <= w_data[8*gi +: 8];
          end else begin
            rd_q <= mem[r_idx];
          end
        end
      end

      assign r_data[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_ram_be.sv
// Self-checking bench for dual_ram_be: directed vector table, reset/clear sequences,
// and random traffic compared against an array model of the memory.
module tb_dual_ram_be;
  localparam int DW      = 32;
  localparam int AW      = 12;
  localparam int MEM_NUM = 16;
  localparam int BW      = DW / 8;
`ifdef DUAL_RAM_INIT_EN
  localparam int EXP_LOW = MEM_NUM;
`else
  localparam int EXP_LOW = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [BW-1:0] w_strb;
  logic          ren;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          ready;

  always #5 clk = ~clk;

  dual_ram_be #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM)) dut (
    .clk    (clk),
    .rst    (rst),
    .wen    (wen),
    .w_addr (w_addr),
    .w_data (w_data),
    .w_strb (w_strb),
    .ren    (ren),
    .r_addr (r_addr),
    .r_data (r_data),
    .r_valid(r_valid),
    .ready  (ready)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [MEM_NUM];
  logic [31:0] last_rd;
  logic        exp_ready;

  typedef struct {
    logic        w;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        r;
    logic [11:0] ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1ns after the rising edge, update the model.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [31:0] wd,
                      input logic [3:0] st, input logic r, input logic [AW-1:0] ra);
    int wi;
    int ri;
    @(negedge clk);
    wen    = w;
    w_addr = wa;
    w_data = wd;
    w_strb = st;
    ren    = r;
    r_addr = ra;
    @(posedge clk);
    #1;
    wi = int'(wa);
    ri = int'(ra);
    if (exp_ready) begin
      // Memory semantics: the write lands first, a read sees the post-write word.
      if (w && wi < MEM_NUM) begin
        for (int i = 0; i < BW; i++) begin
          if (st[i]) model[wi][8*i +: 8] = wd[8*i +: 8];
        end
      end
      if (r) last_rd = (ri < MEM_NUM) ? model[ri] : 32'h0;
    end
    $display("[TB] t=%0t rst=%0b wen=%0b w_addr=%0d w_data=%08h strb=%b ren=%0b r_addr=%0d -> ready=%0b r_valid=%0b r_data=%08h",
             $time, rst, w, wa, wd, st, r, ra, ready, r_valid, r_data);
  endtask

  // Step until ready rises (bounded); returns the number of sampled cycles with ready=0.
  task automatic wait_ready(input logic act, output int lows);
    lows = 0;
    for (int n = 0; n < 100; n++) begin
      step(act, 12'd2, 32'hFFFF_FFFF, 4'hF, act, 12'd2);
      if (ready) break;
      lows++;
      check("clear_rvalid", {31'b0, r_valid}, 32'h0);
      check("clear_rdata", r_data, last_rd);
    end
    exp_ready = 1'b1;
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < MEM_NUM; a++) begin
      step(1'b0, 12'd0, 32'h0, 4'h0, 1'b1, 12'(a));
      check({name, "_valid"}, {31'b0, r_valid}, 32'h1);
      check({name, "_data"}, r_data, model[a]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int a_w;
    int a_r;
    logic w_r;
    logic r_r;

    vt[0]  = '{1'b1, 12'd3,  32'hAABBCCDD, 4'hF, 1'b0, 12'd0,  1'b0, 32'h0};
    vt[1]  = '{1'b1, 12'd3,  32'h11223344, 4'h5, 1'b0, 12'd0,  1'b0, 32'h0};
    vt[2]  = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd3,  1'b1, 32'hAA22CC44};
    vt[3]  = '{1'b1, 12'd5,  32'h12345678, 4'hF, 1'b0, 12'd0,  1'b0, 32'hAA22CC44};
    vt[4]  = '{1'b1, 12'd5,  32'hFFFFFFFF, 4'h8, 1'b1, 12'd5,  1'b1, 32'hFF345678};
    vt[5]  = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd5,  1'b1, 32'hFF345678};
    vt[6]  = '{1'b1, 12'd20, 32'hDEADBEEF, 4'hF, 1'b1, 12'd20, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd3,  1'b1, 32'hAA22CC44};
    vt[8]  = '{1'b1, 12'd7,  32'h0000ABCD, 4'hF, 1'b1, 12'd7,  1'b1, 32'h0000ABCD};
    vt[9]  = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b0, 12'd0,  1'b0, 32'h0000ABCD};
    vt[10] = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b0, 12'd0,  1'b0, 32'h0000ABCD};
    vt[11] = '{1'b1, 12'd7,  32'hFFFFFFFF, 4'h0, 1'b0, 12'd0,  1'b0, 32'h0000ABCD};
    vt[12] = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd7,  1'b1, 32'h0000ABCD};
    vt[13] = '{1'b1, 12'd9,  32'h55AA55AA, 4'hF, 1'b0, 12'd0,  1'b0, 32'h0000ABCD};
    vt[14] = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd9,  1'b1, 32'h55AA55AA};
    vt[15] = '{1'b1, 12'd10, 32'hCAFEF00D, 4'hF, 1'b1, 12'd9,  1'b1, 32'h55AA55AA};
    vt[16] = '{1'b0, 12'd0,  32'h0,        4'h0, 1'b1, 12'd10, 1'b1, 32'hCAFEF00D};

    for (int i = 0; i < MEM_NUM; i++) model[i] = 32'h0;
    last_rd   = 32'h0;
    exp_ready = 1'b0;
    rst    = 1'b1;
    wen    = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_strb = '0;
    ren    = 1'b0;
    r_addr = '0;

    // Reset state over two reset cycles, then time the rise of ready.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 12'd0, 32'h0, 4'h0, 1'b0, 12'd0);
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_rvalid", {31'b0, r_valid}, 32'h0);
      check("rst_rdata", r_data, 32'h0);
    end
    rst = 1'b0;
    wait_ready(1'b0, lows);
    check("init_ready_low_cycles", 32'(lows), 32'(EXP_LOW));

`ifndef DUAL_RAM_INIT_EN
    for (int a = 0; a < MEM_NUM; a++) step(1'b1, 12'(a), 32'h0, 4'hF, 1'b0, 12'd0);
`endif
    for (int a = 0; a < MEM_NUM; a++) begin
      step(1'b0, 12'd0, 32'h0, 4'h0, 1'b1, 12'(a));
      check("init_rd_valid", {31'b0, r_valid}, 32'h1);
      check("init_rd_data", r_data, 32'h0);
    end

    // Directed vectors: byte mask, collision, out of range, hold, back-to-back, disjoint ports.
    for (int i = 0; i < 17; i++) begin
      step(vt[i].w, vt[i].wa, vt[i].wd, vt[i].st, vt[i].r, vt[i].ra);
      check($sformatf("vec%0d_valid", i), {31'b0, r_valid}, {31'b0, vt[i].ev});
      check($sformatf("vec%0d_data", i), r_data, vt[i].ed);
    end
    sweep("vec_sweep");

    // Random traffic, including out-of-range addresses and partial strobes.
    for (int n = 0; n < 400; n++) begin
      w_r = 1'($urandom_range(0, 1));
      r_r = 1'($urandom_range(0, 1));
      a_w = $urandom_range(0, MEM_NUM + 3);
      a_r = (n % 5 == 0) ? a_w : $urandom_range(0, MEM_NUM + 3);
      step(w_r, 12'(a_w), $urandom, 4'($urandom), r_r, 12'(a_r));
      check("rnd_ready", {31'b0, ready}, 32'h1);
      check("rnd_valid", {31'b0, r_valid}, {31'b0, r_r});
      check("rnd_data", r_data, last_rd);
    end
    sweep("rnd_sweep");

    // Reset pulsed partway through the clear; traffic during the clear must be ignored.
    rst = 1'b1;
    exp_ready = 1'b0;
    last_rd = 32'h0;
    step(1'b0, 12'd0, 32'h0, 4'h0, 1'b0, 12'd0);
    step(1'b0, 12'd0, 32'h0, 4'h0, 1'b0, 12'd0);
    check("rst2_rdata", r_data, 32'h0);
    rst = 1'b0;
`ifdef DUAL_RAM_INIT_EN
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 12'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 12'd2);
      check("midclr_ready", {31'b0, ready}, 32'h0);
      check("midclr_rvalid", {31'b0, r_valid}, 32'h0);
    end
    rst = 1'b1;
    step(1'b1, 12'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 12'd2);
    check("midclr_rst_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < MEM_NUM; i++) model[i] = 32'h0;
`endif
    wait_ready(1'b1, lows);
    check("midclr_ready_low_cycles", 32'(lows), 32'(EXP_LOW));
    sweep("post_rst_sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
